// File: rtl/twiddle_rom_q.sv
// FFT twiddle-factor generator: quarter-wave sine table folded into cos / -+sin
// for any index k in [0,N), behind a two-stage valid/ready pipeline.
module twiddle_rom_q #(
  parameter int unsigned COEF_W    = 32,
  parameter int unsigned LOG2N     = 9,
  parameter              INIT_FILE = "sin_quarter.dat"
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LOG2N-1:0]    in_k,
  input  logic                in_inv,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*COEF_W-1:0] out_data
);

  localparam int unsigned R_W   = LOG2N - 2;
  localparam int unsigned QN    = 1 << R_W;
  localparam int unsigned IDX_W = R_W + 1;
  localparam int unsigned FX    = 60;
  localparam int unsigned ACC_W = 128;
  localparam logic [63:0] PI_FX = 64'h3243F6A8885A308D;

  // INIT_FILE names the hex image of this table; the contents below are the
  // same values, generated at elaboration so no external image is required.
  logic unused_init;
  assign unused_init = ^INIT_FILE;

  // round(sin(2*pi*idx/N) * (2^(COEF_W-1)-1)) via fixed-point Taylor series.
  function automatic logic [COEF_W-1:0] quarter_sin(input int idx);
    logic signed [ACC_W-1:0] th;
    logic signed [ACC_W-1:0] th2;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] fs;
    logic signed [ACC_W-1:0] res;
    th   = ($signed(ACC_W'(PI_FX)) * $signed(ACC_W'(idx))) >>> (LOG2N - 1);
    th2  = (th * th) >>> FX;
    term = th;
    acc  = th;
    for (int n = 1; n <= 16; n++) begin
      term = -(((term * th2) >>> FX) / $signed(ACC_W'(4 * n * n + 2 * n)));
      acc  = acc + term;
    end
    fs  = $signed((ACC_W'(1) << (COEF_W - 1)) - ACC_W'(1));
    res = (acc * fs + $signed(ACC_W'(1) << (FX - 1))) >>> FX;
    if (res > fs) res = fs;
    if (res < 0)  res = '0;
    return COEF_W'(res);
  endfunction

  logic [COEF_W-1:0] tbl [QN+1];

  for (genvar g = 0; g <= int'(QN); g++) begin : g_tbl
    localparam logic [COEF_W-1:0] ENTRY = quarter_sin(g);
    assign tbl[g] = ENTRY;
  end

  logic              adv;
  logic              accept;
  logic [1:0]        k_q;
  logic [R_W-1:0]    k_r;
  logic [IDX_W-1:0]  idx_a;
  logic [IDX_W-1:0]  idx_b;

  logic              v1;
  logic [1:0]        q1;
  logic              inv1;
  logic [COEF_W-1:0] a1;
  logic [COEF_W-1:0] b1;

  logic [COEF_W-1:0] c_c;
  logic [COEF_W-1:0] s_c;
  logic [COEF_W-1:0] im_c;

  // The whole pipe moves whenever the output slot is empty or being drained.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  assign k_q   = in_k[LOG2N-1 -: 2];
  assign k_r   = in_k[R_W-1:0];
  assign idx_a = {1'b0, k_r};
  assign idx_b = IDX_W'(QN) - idx_a;

  // S1: capture quadrant, mode and the two mirrored table reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      q1   <= 2'd0;
      inv1 <= 1'b0;
      a1   <= '0;
      b1   <= '0;
    end else if (adv) begin
      v1 <= accept;
      if (accept) begin
        q1   <= k_q;
        inv1 <= in_inv;
        a1   <= tbl[idx_a];
        b1   <= tbl[idx_b];
      end
    end
  end

  // Quadrant folding of the stored first-quadrant pair.
  always_comb begin
    c_c = b1;
    s_c = a1;
    case (q1)
      2'd0: begin
        c_c = b1;
        s_c = a1;
      end
      2'd1: begin
        c_c = -a1;
        s_c = b1;
      end
      2'd2: begin
        c_c = -b1;
        s_c = -a1;
      end
      default: begin
        c_c = a1;
        s_c = -b1;
      end
    endcase
  end

  assign im_c = inv1 ? s_c : -s_c;

  // S2: output register, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      out_valid <= v1;
      if (v1) out_data <= {c_c, im_c};
    end
  end

endmodule

// File: tb/tb_twiddle_rom_q.sv
// Randomised bench for twiddle_rom_q: float reference model, age-based
// valid/ready scoreboard, quadrant symmetry sweep, back-pressure and reset.
module tb_twiddle_rom_q;

  localparam int unsigned COEF_W = 32;
  localparam int unsigned LOG2N  = 9;
  localparam int          N      = 512;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [LOG2N-1:0]    in_k;
  logic                in_inv;
  logic                out_valid;
  logic                out_ready;
  logic [2*COEF_W-1:0] out_data;

  twiddle_rom_q #(
    .COEF_W    (COEF_W),
    .LOG2N     (LOG2N),
    .INIT_FILE ("sin_quarter.dat")
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_k      (in_k),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  typedef struct {
    int          k;
    bit          inv;
    logic [63:0] exp;
    int          tol;
    int          acc;
  } req_t;

  req_t        exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          mon_en = 0;
  bit          rnd_ready = 0;
  bit          have_prev = 0;
  bit          saw_block = 0;
  logic [63:0] prev_data;
  int          cur_k;
  bit          cur_inv;
  logic [63:0] cur_exp;
  int          cur_tol;
  logic [31:0] sw_re [N];
  logic [31:0] sw_im [N];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Compares the two signed 32-bit halves with an absolute tolerance.
  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp, input int tol);
    longint dre;
    longint dim;
    n_vec++;
    dre = longint'($signed(got[63:32])) - longint'($signed(exp[63:32]));
    dim = longint'($signed(got[31:0]))  - longint'($signed(exp[31:0]));
    if (dre < 0) dre = -dre;
    if (dim < 0) dim = -dim;
    if (dre > longint'(tol) || dim > longint'(tol)) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (tol %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic longint rnd(input real x);
    if (x >= 0.0) return longint'($rtoi(x + 0.5));
    return -longint'($rtoi(-x + 0.5));
  endfunction

  function automatic logic [63:0] model(input int k, input bit inv);
    real    ang;
    real    fs;
    longint re;
    longint im;
    fs  = 2147483647.0;
    ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(N);
    re  = rnd($cos(ang) * fs);
    im  = rnd($sin(ang) * fs);
    if (!inv) im = -im;
    return {32'(re), 32'(im)};
  endfunction

  // Scoreboard: a result is due at the output once it is two edges old.
  always @(negedge clk) begin : mon
    req_t h;
    int   e;
    bit   ov_m;
    if (!rst_n) begin
      exp_q.delete();
      have_prev = 0;
    end else if (mon_en) begin
      e    = cyc + 1;
      ov_m = (exp_q.size() > 0) && (exp_q[0].acc + 2 <= e);
      check("out_valid", 64'(out_valid), 64'(ov_m), 0);
      check("in_ready", 64'(in_ready), 64'(!ov_m || out_ready), 0);
      if (ov_m) begin
        h = exp_q[0];
        check($sformatf("data k=%0d inv=%0d", h.k, h.inv), out_data, h.exp, h.tol);
        if (have_prev) check("stall_hold", out_data, prev_data, 0);
        if (!in_ready) saw_block = 1;
        if (out_ready) begin
          if (!h.inv) begin
            sw_re[h.k] = out_data[63:32];
            sw_im[h.k] = out_data[31:0];
          end
          void'(exp_q.pop_front());
          have_prev = 0;
        end else begin
          have_prev = 1;
          prev_data = out_data;
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back('{cur_k, cur_inv, cur_exp, cur_tol, e});
    end
  end

  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input int k, input bit inv, input logic [63:0] exp, input int tol);
    int n;
    bit done;
    n        = 0;
    done     = 0;
    cur_k    = k;
    cur_inv  = inv;
    cur_exp  = exp;
    cur_tol  = tol;
    in_valid = 1'b1;
    in_k     = LOG2N'(k);
    in_inv   = inv;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 64) begin
        check("send_timeout", 64'(0), 64'(1), 0);
        done = 1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'(0), 0);
  endtask

  initial begin
    int          k;
    bit          inv;
    int          n;
    logic [31:0] tmp;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_k      = '0;
    in_inv    = 1'b0;
    out_ready = 1'b1;
    cur_k     = 0;
    cur_inv   = 0;
    cur_exp   = '0;
    cur_tol   = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0), 0);
    check("rst_out_data", out_data, 64'(0), 0);
    check("rst_in_ready", 64'(in_ready), 64'(1), 0);
    rst_n  = 1'b1;
    mon_en = 1;

    // Quadrant corners, forward, then inverse at k=N/4.
    send(0,   0, 64'h7FFFFFFF_00000000, 0);
    send(128, 0, 64'h00000000_80000001, 0);
    send(256, 0, 64'h80000001_00000000, 0);
    send(384, 0, 64'h00000000_7FFFFFFF, 0);
    send(128, 1, 64'h00000000_7FFFFFFF, 0);
    drain();

    for (int i = 0; i < N; i++) send(i, 0, model(i, 0), 1);
    drain();
    for (int i = 1; i < N; i++) begin
      if (i != N / 2)
        check($sformatf("sym_re k=%0d", i), {32'd0, sw_re[i]}, {32'd0, sw_re[N-i]}, 0);
      tmp = -sw_im[N-i];
      check($sformatf("sym_im k=%0d", i), {32'd0, sw_im[i]}, {32'd0, tmp}, 0);
    end

    // Idle gaps between requests.
    for (int i = 0; i < 12; i++) begin
      k   = int'($urandom_range(0, N - 1));
      inv = 1'($urandom_range(0, 1));
      send(k, inv, model(k, inv), 1);
      idle(int'($urandom_range(1, 3)));
    end
    drain();

    // Back-pressure: out_ready low for 5 cycles after the first result.
    saw_block = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(40 * i + 3, 0, model(40 * i + 3, 0), 1);
      end
      begin
        n = 0;
        while (!out_valid && n < 50) begin
          @(posedge clk);
          #1;
          n++;
        end
        check("bp_first_valid", 64'(out_valid), 64'(1), 0);
        out_ready = 1'b0;
        repeat (5) begin
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_in_ready_blocked", 64'(saw_block), 64'(1), 0);

    // Random indices, modes, gaps and consumer stalls.
    rnd_ready = 1;
    for (int i = 0; i < 300; i++) begin
      k   = int'($urandom_range(0, N - 1));
      inv = 1'($urandom_range(0, 1));
      send(k, inv, model(k, inv), 1);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    in_valid  = 1'b0;
    rnd_ready = 0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Reset with two requests in flight.
    send(5,   0, model(5, 0), 1);
    send(300, 1, model(300, 1), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'(0), 0);
    check("async_rst_out_data", out_data, 64'(0), 0);
    check("async_rst_in_ready", 64'(in_ready), 64'(1), 0);
    @(posedge clk);
    #1;
    check("rst_flush", 64'(exp_q.size()), 64'(0), 0);
    rst_n = 1'b1;
    idle(2);
    send(77, 0, model(77, 0), 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/twiddle_rom_q.md
Name: twiddle_rom_q

Overview:
- Parametrised FFT twiddle-factor generator; successor to the flat full-period sin/cos ROM.
- Stores only a quarter-wave sine table of N/4+1 entries and rebuilds cos and ∓sin for any index k in [0,N) by quadrant folding.
- Adds a valid/ready pipeline with back-pressure and a forward/inverse (conjugate) mode.
- Sits between the FFT butterfly address sequencer and the complex multiplier.

Parameters:
- COEF_W, 32: width of each real/imag coefficient; signed Q1.(COEF_W-1).
- LOG2N, 9: log2 of FFT length N (N = 512); minimum 3.
- INIT_FILE, "sin_quarter.dat": hex file, N/4+1 words, T[i] = round(sin(2πi/N)·(2^(COEF_W-1)-1)).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_k  in  LOG2N  twiddle index k.
- in_inv  in  1  0 = forward W = cos − j·sin; 1 = inverse W = cos + j·sin.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_data  out  2·COEF_W  {re, im}; re = out_data[2·COEF_W-1:COEF_W].

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is asynchronous and active-low.
  - While rst_n = 0: all pipeline valid flags = 0, out_valid = 0, out_data = 0. in_ready follows its equation below, so it reads 1.
  - Table contents are loaded from INIT_FILE at initialisation and are not affected by reset.
- Pipeline (two stages S1, S2; latency 2 cycles from accept to out_valid):
  - Global advance: adv = !v2 || out_ready. in_ready = adv (combinational).
  - S1, on accept: split k = {q[1:0], r}, where r has LOG2N-2 bits. Q = N/4.
    - Read A = T[r] and B = T[Q−r] from a two-read-port table.
    - When r = 0, B = T[Q].
    - Register q, in_inv, A, B and v1.
  - S2, when adv: compute c and s by quadrant.
    - q=0: c = B, s = A.
    - q=1: c = −A, s = B.
    - q=2: c = −B, s = −A.
    - q=3: c = A, s = −B.
  - S2 output: re = c; im = in_inv ? s : −s. Register out_data and v2.
  - When adv = 0, S1 and S2 hold their contents and new requests are not accepted.
- Arithmetic:
  - Two's-complement negation at COEF_W bits.
  - The table never contains −2^(COEF_W-1), so negation cannot overflow.
  - Full scale is ±(2^(COEF_W-1)−1); T[Q] = 0x7FFF…F.
  - Negating 0 yields 0; no −0 is produced.
- Boundary conditions:
  - Back-to-back requests sustain 1 result per cycle while out_ready = 1.
  - out_ready low with both stages full: in_ready = 0. out_data and out_valid stay stable until the handshake completes.
  - out_ready rising: the held result transfers, and the S1 content moves to S2 in the same cycle.
  - k = N−1 folds to q = 3, r = Q−1. There is no out-of-range index; T has Q+1 entries, indices 0..Q.
  - Reset mid-operation: in-flight requests are discarded and no stale out_valid appears after release.
  - After reset release, the first accept produces out_valid exactly 2 cycles later, with out_ready = 1.

Test Plan:
- N=512, W=32, forward, out_ready=1: issue k = 0, 128, 256, 384 back-to-back. Required outputs, two cycles later, one per cycle:
  - k=0: {0x7FFFFFFF, 0x00000000}
  - k=128: {0x00000000, 0x80000001}
  - k=256: {0x80000001, 0x00000000}
  - k=384: {0x00000000, 0x7FFFFFFF}
- Inverse mode, k=128 → {0x00000000, 0x7FFFFFFF}. Random k with random in_inv must match a float model, |error| ≤ 1 LSB versus round(cos/sin·(2^31−1)).
- Sweep all k = 0..511 forward. Check that quadrant symmetry holds exactly:
  - re(k) = re(N−k)
  - im(k) = −im(N−k)
- Back-pressure: stream 8 requests while out_ready is held low for 5 cycles after the first out_valid.
  - in_ready deasserts once 2 results are pending.
  - out_data stays stable.
  - No result is lost or duplicated; the order is preserved.
- Assert rst_n low for 1 cycle with 2 requests in flight:
  - out_valid = 0 and out_data = 0 immediately, asynchronously.
  - The first request after release yields a result 2 cycles later.
- in_valid = 0 idle gaps interleaved with requests: out_valid pulses only for accepted requests, each exactly 2 cycles after its accept.
